// File: rtl/bus_arbiter_rr8.sv
// bus_arbiter_rr8: round-robin arbiter for one 16-bit bus shared by 8 requesters.
// Latency: 1 cycle from request sampled in IDLE to registered grant; one dead
// cycle after each tenure. Owner keeps the bus until it drops req, with no preemption.
// Optional feature macro: ARB_TIMEOUT_EN limits a tenure to MAX_HOLD grant cycles.
module bus_arbiter_rr8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       bus_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Stop elaboration when the counter is too narrow for the hold limit.
  if (MAX_HOLD < 2 || (64'd1 << HOLD_W) <= 64'(MAX_HOLD)) begin : g_bad_params
    $error("bus_arbiter_rr8: need MAX_HOLD >= 2 and 2**HOLD_W > MAX_HOLD");
  end

  state_t            state_q, state_d;
  logic [7:0]        gnt_q, gnt_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [2:0]        win_idx;
  logic              win_found;
  logic [2:0]        scan_idx;
  logic              owner_req;
  logic              hold_expired;

  // sel_q always holds the owner index while in GRANT.
  assign owner_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
  assign hold_expired = (cnt_q == HOLD_W'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  // Round-robin search: first active request starting at ptr, wrapping modulo 8.
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    scan_idx  = ptr_q;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/GRANT/RELEASE FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = 8'h00;
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 8'h01 << win_idx;
          sel_d   = win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_req || hold_expired) begin
          // Moving ptr past the owner gives it lowest priority next round.
          state_d   = RELEASE;
          gnt_d     = 8'h00;
          ptr_d     = sel_q + 3'd1;
          timeout_d = owner_req && hold_expired;
        end
        // Counter saturates so an unbounded tenure never wraps it.
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  // State and output registers; reset overrides any tenure in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 8'h00;
      sel_q     <= 3'd0;
      ptr_q     <= 3'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = |gnt_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr8.sv
// Bench for bus_arbiter_rr8: per-cycle expectations queued as stimulus is applied,
// then popped and compared one cycle later after the clock edge.
// Built with MAX_HOLD=4; the timeout scenario adapts to ARB_TIMEOUT_EN.
module tb_bus_arbiter_rr8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;
  logic       timeout;

  always #5 clk = ~clk;

  bus_arbiter_rr8 #(.MAX_HOLD(4), .HOLD_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
  endtask

  // Apply one cycle of inputs, queue the outputs expected after the next edge, compare.
  task automatic cyc(input logic rst, input logic [7:0] r, input logic [7:0] eg,
                     input logic [2:0] es, input logic et, input string tag);
    exp_t e;
    exp_t o;
    @(negedge clk);
    reset = rst;
    req   = r;
    e.gnt = eg;
    e.sel = es;
    e.to  = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'(0), 32'(1));
    end else begin
      o = exp_q.pop_front();
      check_val({tag, ".gnt"},   32'(gnt),       32'(o.gnt));
      check_val({tag, ".sel"},   32'(sel),       32'(o.sel));
      check_val({tag, ".valid"}, 32'(bus_valid), 32'(o.gnt != 8'h00));
      check_val({tag, ".tmo"},   32'(timeout),   32'(o.to));
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;

    // Reset holds everything at zero even with all requests high.
    cyc(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "rst0");
    cyc(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "rst1");

    // Single requester 4 held three cycles, then release and idle.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h10, 8'h10, 3'd4, 1'b0, $sformatf("own4_%0d", i));
    cyc(1'b0, 8'h00, 8'h00, 3'd4, 1'b0, "rel4");
    cyc(1'b0, 8'h00, 8'h00, 3'd4, 1'b0, "idle4");
    // ptr now 5: requesters 0 and 5 together -> 5 wins.
    cyc(1'b0, 8'h21, 8'h20, 3'd5, 1'b0, "ptr5");
    cyc(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, "rel5");
    cyc(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, "idle5");

    // ptr now 6: requesters 0 and 6 together -> 6 first, then 0.
    cyc(1'b0, 8'h41, 8'h40, 3'd6, 1'b0, "ptr6_g6");
    cyc(1'b0, 8'h01, 8'h00, 3'd6, 1'b0, "ptr6_rel");
    cyc(1'b0, 8'h01, 8'h00, 3'd6, 1'b0, "ptr6_idle");
    cyc(1'b0, 8'h01, 8'h01, 3'd0, 1'b0, "ptr6_g0");
    cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "rel0");
    cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "idle0");

    // All requesting from ptr=0, each drops after one grant cycle: order 0..7,0.
    cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "rst_rr");
    for (int k = 0; k < 9; k++) begin
      logic [2:0] ob;
      logic [7:0] om;
      ob = 3'(k);
      om = 8'h01 << ob;
      cyc(1'b0, 8'hFF,       om,    ob, 1'b0, $sformatf("rr%0d_g", k));
      cyc(1'b0, 8'hFF & ~om, 8'h00, ob, 1'b0, $sformatf("rr%0d_rel", k));
      cyc(1'b0, 8'hFF,       8'h00, ob, 1'b0, $sformatf("rr%0d_idle", k));
    end
    cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "rr_end");

    // Requester 1 holds its request indefinitely.
    cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "rst_to");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 8'h02, 8'h02, 3'd1, 1'b0, $sformatf("hold%0d", i));
`ifdef ARB_TIMEOUT_EN
    cyc(1'b0, 8'h02, 8'h00, 3'd1, 1'b1, "to_pulse");
    cyc(1'b0, 8'h02, 8'h00, 3'd1, 1'b0, "to_idle");
    cyc(1'b0, 8'h02, 8'h02, 3'd1, 1'b0, "to_regrant");
    cyc(1'b0, 8'h00, 8'h00, 3'd1, 1'b0, "to_rel");
`else
    for (int i = 4; i < 40; i++)
      cyc(1'b0, 8'h02, 8'h02, 3'd1, 1'b0, $sformatf("hold%0d", i));
    cyc(1'b0, 8'h00, 8'h00, 3'd1, 1'b0, "hold_rel");
`endif

    // Reset in the middle of requester 3's tenure.
    cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "rst_mid0");
    cyc(1'b0, 8'h08, 8'h08, 3'd3, 1'b0, "mid_g3a");
    cyc(1'b0, 8'h08, 8'h08, 3'd3, 1'b0, "mid_g3b");
    cyc(1'b1, 8'h08, 8'h00, 3'd0, 1'b0, "mid_rst");
    cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "mid_idle");
    // ptr back at 0: all requesting -> requester 0.
    cyc(1'b0, 8'hFF, 8'h01, 3'd0, 1'b0, "mid_ptr0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
